// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - shared constants and helpers for the multi-channel tick generator
package tick_gen_pkg;

  localparam int CNT_W_DEF = 27;

  localparam int DIV_100MHZ_1HZ   = 100_000_000;
  localparam int DIV_100MHZ_2HZ   = 50_000_000;
  localparam int DIV_100MHZ_4HZ   = 25_000_000;
  localparam int DIV_100MHZ_400HZ = 250_000;

  // Channel-select width; a single channel still needs a 1-bit select port.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen_chan.sv
// rtl/tick_gen_chan.sv - one divider channel with glitch-free divisor reload
// Square output flop exists only when TICK_GEN_SQUARE_EN is defined.
module tick_gen_chan
  import tick_gen_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_div,
  output logic             tick,
  output logic             sq
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] div_m1_q;
  logic [CNT_W-1:0] pend_q;
  logic             pend_vld_q;
  logic             tick_q;

  logic             wrap_d;
  logic             apply_d;
  logic             load_vld_d;
  logic [CNT_W-1:0] load_div_d;

  // >= rather than == so a divisor shrunk below a held count still wraps at once.
  always_comb begin
    wrap_d     = en && (cnt_q >= div_m1_q);
    apply_d    = clr || !en || wrap_d;
    load_vld_d = ld || pend_vld_q;
    load_div_d = ld ? ld_div : pend_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      div_m1_q   <= DIV_RST - CNT_W'(1);
      pend_q     <= DIV_RST;
      pend_vld_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      if (apply_d && load_vld_d) begin
        div_m1_q   <= load_div_d - CNT_W'(1);
        pend_vld_q <= 1'b0;
      end else if (ld) begin
        pend_vld_q <= 1'b1;
      end
      if (ld) begin
        pend_q <= ld_div;
      end

      if (clr) begin
        cnt_q  <= '0;
        tick_q <= 1'b0;
      end else if (wrap_d) begin
        cnt_q  <= '0;
        tick_q <= 1'b1;
      end else begin
        tick_q <= 1'b0;
        if (en) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign tick = tick_q;

`ifdef TICK_GEN_SQUARE_EN
  logic sq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sq_q <= 1'b0;
    end else if (clr) begin
      sq_q <= 1'b0;
    end else if (wrap_d) begin
      sq_q <= ~sq_q;
    end
  end

  assign sq = sq_q;
`else
  assign sq = 1'b0;
`endif

endmodule

// File: rtl/tick_gen_multi.sv
// rtl/tick_gen_multi.sv - NUM_CH programmable tick channels with config decode
// Optional square outputs enabled by defining TICK_GEN_SQUARE_EN.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int                      NUM_CH   = 4,
  parameter int                      CNT_W    = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {NUM_CH{CNT_W'(1)}},
  localparam int                     CH_W     = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  logic ack_q;
  logic err_q;
  logic legal_d;

  always_comb begin
    legal_d = cfg_wr && (cfg_div != '0) && (int'(cfg_ch) < NUM_CH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= legal_d;
      err_q <= cfg_wr && !legal_d;
    end
  end

  assign cfg_ack = ack_q;
  assign cfg_err = err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    tick_gen_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en[i]),
      .clr    (sync_clr),
      .ld     (legal_d && (int'(cfg_ch) == i)),
      .ld_div (cfg_div),
      .tick   (tick[i]),
      .sq     (sq[i])
    );
  end

endmodule
